// File: rtl/frame_scan_out_if.sv
// Stream/control bundle for the frame unloader.
// master = unloader side, slave = frame source and byte sink.
interface frame_scan_out_if #(
    parameter int NBYTES = 19,
    parameter int BW     = 8
);
    logic                   load;
    logic [NBYTES*BW-1:0]   frame_in;
    logic                   abort;
    logic                   busy;
    logic [BW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   done;

    modport master (
        input  load, frame_in, abort, out_ready,
        output busy, out_data, out_valid, out_last, done
    );

    modport slave (
        output load, frame_in, abort, out_ready,
        input  busy, out_data, out_valid, out_last, done
    );
endinterface

// File: rtl/frame_scan_out.sv
// Parallel-to-serial frame unloader: captures a whole frame in one
// cycle, then streams it out byte 0 first over valid/ready.
module frame_scan_out #(
    parameter int NBYTES = 19,
    parameter int BW     = 8
) (
    input  logic               clk,
    input  logic               rst,
    frame_scan_out_if.master   bus
);
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NBYTES-1:0][BW-1:0]  buf_q, buf_d;
    logic                       done_q, done_d;
    logic                       sending;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort beats a same-cycle load
                if (bus.load && !bus.abort) begin
                    buf_d   = bus.frame_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (bus.out_ready) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode registered state only; out_ready never reaches them.
    assign sending       = (state_q == SEND);
    assign bus.busy      = sending;
    assign bus.out_valid = sending;
    assign bus.out_last  = sending && (idx_q == LAST);
    assign bus.out_data  = sending ? buf_q[idx_q] : '0;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_frame_scan_out.sv
// Directed bench for frame_scan_out with a shift-in store model
// on the output stream for round-trip checking.
module tb_frame_scan_out;
    localparam int NBYTES = 19;
    localparam int BW     = 8;
    localparam int FW     = NBYTES * BW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [FW-1:0] store;
    logic [FW-1:0] ref_frame;

    frame_scan_out_if #(.NBYTES(NBYTES), .BW(BW)) bus ();

    frame_scan_out #(.NBYTES(NBYTES), .BW(BW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 19-byte shift-in store: first byte ends up at the bottom.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready)
            store <= {bus.out_data, store[FW-1:BW]};
    end

    task automatic chk(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [7:0] base,
                                         input bit x);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NBYTES; i++)
            f[i*BW +: BW] = x ? (base ^ 8'(i)) : (base + 8'(i));
        return f;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"},  bus.out_last, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_data"},  bus.out_data, 0);
    endtask

    logic [15:0] pat;
    logic        r;
    logic        prev_r;
    logic [7:0]  prev_d;
    int          e;
    int          c;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        store = '0;
        rst = 1'b0;
        bus.load = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        bus.frame_in = '0;
        pat = 16'b1101_0011_0100_1001;

        // async reset mid-cycle, before any clock edge
        #3 rst = 1'b1;
        #1 chk_zero("rst_async");
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_zero("rst_idle");

        // single frame, ready high
        bus.frame_in = mk(8'h10, 0);
        bus.out_ready = 1'b1;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            chk("s_busy",  bus.busy, 1);
            chk("s_valid", bus.out_valid, 1);
            chk("s_data",  bus.out_data, 8'(8'h10 + k));
            chk("s_last",  bus.out_last, (k == NBYTES - 1));
            chk("s_done",  bus.done, 0);
            tick();
        end
        chk("s_done_hi", bus.done, 1);
        chk("s_busy_lo", bus.busy, 0);
        chk("s_valid_lo", bus.out_valid, 0);
        tick();
        chk("s_done_once", bus.done, 0);

        // backpressure
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        e = 0;
        c = 0;
        prev_r = 1'b1;
        prev_d = '0;
        while (e < NBYTES && c < 200) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 8'(8'h10 + e));
            if (!prev_r)
                chk("bp_hold", bus.out_data, prev_d);
            r = pat[c % 16];
            bus.out_ready = r;
            prev_r = r;
            prev_d = bus.out_data;
            if (r)
                e++;
            tick();
            c++;
        end
        chk("bp_count", e, NBYTES);
        chk("bp_done", bus.done, 1);
        bus.out_ready = 1'b1;
        tick();

        // round trip into the shift-in store
        ref_frame = mk(8'hA0, 1);
        bus.frame_in = ref_frame;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            tick();
            c++;
        end
        chk("rt_done", bus.done, 1);
        chk("rt_frame", store, ref_frame);
        tick();

        // ignored load at byte 5, abort at byte 7
        bus.frame_in = mk(8'h10, 0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 5; k++)
            tick();
        chk("il_b5", bus.out_data, 8'h15);
        bus.frame_in = mk(8'hB0, 0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.frame_in = mk(8'h10, 0);
        chk("il_b6", bus.out_data, 8'h16);
        tick();
        chk("il_b7", bus.out_data, 8'h17);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_valid", bus.out_valid, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        tick();
        chk("ab_done2", bus.done, 0);

        // abort and load together in idle
        bus.abort = 1'b1;
        bus.load = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abld_busy", bus.busy, 0);
        tick();
        bus.load = 1'b0;
        chk("reload_b0", bus.out_data, 8'h10);
        chk("reload_valid", bus.out_valid, 1);

        // reset mid-frame at byte 10
        for (int k = 0; k < 10; k++)
            tick();
        chk("mr_b10", bus.out_data, 8'h1A);
        #3 rst = 1'b1;
        #1 chk_zero("mr_async");
        tick();
        rst = 1'b0;
        chk("mr_done", bus.done, 0);
        tick();
        chk_zero("mr_after");

        // back-to-back, with a load on the final transfer ignored
        bus.frame_in = mk(8'h10, 0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < NBYTES - 1; k++)
            tick();
        chk("bb_last", bus.out_last, 1);
        chk("bb_b18", bus.out_data, 8'h22);
        bus.frame_in = mk(8'hC0, 0);
        bus.load = 1'b1;
        tick();
        chk("bb_done", bus.done, 1);
        chk("bb_ign", bus.busy, 0);
        bus.frame_in = mk(8'h30, 0);
        tick();
        bus.load = 1'b0;
        chk("bb_valid", bus.out_valid, 1);
        chk("bb_b0", bus.out_data, 8'h30);
        for (int k = 0; k < NBYTES - 1; k++)
            tick();
        chk("bb2_b18", bus.out_data, 8'h42);
        chk("bb2_last", bus.out_last, 1);
        tick();
        chk("bb2_done", bus.done, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
